// File: rtl/loom_scan_seq.sv
// AXI-Lite master sequencer that expands a capture/restore command into the scan controller's register transactions.
// Optional `LOOM_SCAN_SEQ_CHECK_LENGTH_EN` inserts a LENGTH read that aborts on a chain-length mismatch.
module loom_scan_seq #(
  parameter int CHAIN_LENGTH = 64,
  parameter int POLL_LIMIT   = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_op_i,
  input  logic        din_valid_i,
  output logic        din_ready_o,
  input  logic [31:0] din_data_i,
  output logic        dout_valid_o,
  input  logic        dout_ready_i,
  output logic [31:0] dout_data_o,
  output logic        dout_last_o,
  output logic        done_o,
  output logic [1:0]  err_o,
  output logic        busy_o,
  output logic [11:0] m_axil_awaddr,
  output logic        m_axil_awvalid,
  input  logic        m_axil_awready,
  output logic [31:0] m_axil_wdata,
  output logic        m_axil_wvalid,
  input  logic        m_axil_wready,
  input  logic [1:0]  m_axil_bresp,
  input  logic        m_axil_bvalid,
  output logic        m_axil_bready,
  output logic [11:0] m_axil_araddr,
  output logic        m_axil_arvalid,
  input  logic        m_axil_arready,
  input  logic [31:0] m_axil_rdata,
  input  logic [1:0]  m_axil_rresp,
  input  logic        m_axil_rvalid,
  output logic        m_axil_rready
);

  localparam int N_WORDS = (CHAIN_LENGTH + 31) / 32;
  localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int POLL_W  = $clog2(POLL_LIMIT + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(N_WORDS - 1);
  localparam logic [POLL_W-1:0] POLL_LAST   = POLL_W'(POLL_LIMIT - 1);
  localparam logic [11:0]       ADDR_STATUS = 12'h000;
  localparam logic [11:0]       ADDR_CTRL   = 12'h004;
  localparam logic [11:0]       ADDR_DATA   = 12'h010;
`ifdef LOOM_SCAN_SEQ_CHECK_LENGTH_EN
  localparam logic [11:0]       ADDR_LENGTH = 12'h008;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_RD,
    S_DATA_WR,
    S_CTRL_WR,
    S_POLL_RD,
    S_DATA_RD,
    S_CLR_WR,
    S_FIN
  } state_t;

  state_t              state_reg;
  logic                op_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [POLL_W-1:0]   poll_cnt_reg;
  logic                act_reg;
  logic                cmd_ready_reg;
  logic                busy_reg;
  logic                done_reg;
  logic [1:0]          err_reg;
  logic                din_ready_reg;
  logic                dout_valid_reg;
  logic [31:0]         dout_data_reg;
  logic                dout_last_reg;
  logic [11:0]         aw_addr_reg;
  logic                aw_valid_reg;
  logic [31:0]         w_data_reg;
  logic                w_valid_reg;
  logic                b_ready_reg;
  logic [11:0]         ar_addr_reg;
  logic                ar_valid_reg;
  logic                r_ready_reg;

  logic b_fire;
  logic r_fire;
  logic b_err;
  logic r_err;

  assign m_axil_rready = r_ready_reg && !dout_valid_reg;
  assign b_fire        = m_axil_bvalid && b_ready_reg;
  assign r_fire        = m_axil_rvalid && m_axil_rready;
  assign b_err         = (m_axil_bresp != 2'b00);
  assign r_err         = (m_axil_rresp != 2'b00);

  function automatic logic [11:0] data_addr(input logic [IDX_W-1:0] idx);
    return ADDR_DATA + (12'(idx) << 2);
  endfunction

  // act_reg marks the single outstanding AXI transaction of the current state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg      <= S_IDLE;
      op_reg         <= 1'b0;
      idx_reg        <= '0;
      poll_cnt_reg   <= '0;
      act_reg        <= 1'b0;
      cmd_ready_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 2'd0;
      din_ready_reg  <= 1'b0;
      dout_valid_reg <= 1'b0;
      dout_data_reg  <= '0;
      dout_last_reg  <= 1'b0;
      aw_addr_reg    <= '0;
      aw_valid_reg   <= 1'b0;
      w_data_reg     <= '0;
      w_valid_reg    <= 1'b0;
      b_ready_reg    <= 1'b0;
      ar_addr_reg    <= '0;
      ar_valid_reg   <= 1'b0;
      r_ready_reg    <= 1'b0;
    end else begin
      if (aw_valid_reg && m_axil_awready) aw_valid_reg <= 1'b0;
      if (w_valid_reg && m_axil_wready)   w_valid_reg  <= 1'b0;
      if (ar_valid_reg && m_axil_arready) ar_valid_reg <= 1'b0;
      if (b_fire)                         b_ready_reg  <= 1'b0;
      if (r_fire)                         r_ready_reg  <= 1'b0;
      done_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          cmd_ready_reg <= 1'b1;
          if (cmd_valid_i && cmd_ready_reg) begin
            cmd_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            op_reg        <= cmd_op_i;
            idx_reg       <= '0;
            poll_cnt_reg  <= '0;
            err_reg       <= 2'd0;
`ifdef LOOM_SCAN_SEQ_CHECK_LENGTH_EN
            state_reg     <= S_LEN_RD;
            ar_addr_reg   <= ADDR_LENGTH;
            ar_valid_reg  <= 1'b1;
            r_ready_reg   <= 1'b1;
            act_reg       <= 1'b1;
`else
            if (cmd_op_i) begin
              state_reg     <= S_DATA_WR;
              din_ready_reg <= 1'b1;
            end else begin
              // Launch the CONTROL write right away so AW/W appear the cycle after accept.
              state_reg    <= S_CTRL_WR;
              aw_addr_reg  <= ADDR_CTRL;
              w_data_reg   <= 32'h1;
              aw_valid_reg <= 1'b1;
              w_valid_reg  <= 1'b1;
              b_ready_reg  <= 1'b1;
              act_reg      <= 1'b1;
            end
`endif
          end
        end

`ifdef LOOM_SCAN_SEQ_CHECK_LENGTH_EN
        S_LEN_RD: begin
          if (r_fire) begin
            act_reg <= 1'b0;
            if (r_err) begin
              state_reg <= S_FIN;
              done_reg  <= 1'b1;
              err_reg   <= 2'd1;
            end else if (m_axil_rdata != 32'(CHAIN_LENGTH)) begin
              state_reg <= S_FIN;
              done_reg  <= 1'b1;
              err_reg   <= 2'd3;
            end else if (op_reg) begin
              state_reg     <= S_DATA_WR;
              din_ready_reg <= 1'b1;
            end else begin
              state_reg <= S_CTRL_WR;
            end
          end
        end
`endif

        S_DATA_WR: begin
          if (!act_reg) begin
            if (din_valid_i && din_ready_reg) begin
              din_ready_reg <= 1'b0;
              aw_addr_reg   <= data_addr(idx_reg);
              w_data_reg    <= din_data_i;
              aw_valid_reg  <= 1'b1;
              w_valid_reg   <= 1'b1;
              b_ready_reg   <= 1'b1;
              act_reg       <= 1'b1;
            end
          end else if (b_fire) begin
            act_reg <= 1'b0;
            if (b_err) begin
              state_reg <= S_FIN;
              done_reg  <= 1'b1;
              err_reg   <= 2'd1;
            end else if (idx_reg == LAST_IDX) begin
              state_reg <= S_CTRL_WR;
              idx_reg   <= '0;
            end else begin
              idx_reg       <= idx_reg + IDX_W'(1);
              din_ready_reg <= 1'b1;
            end
          end
        end

        S_CTRL_WR: begin
          if (!act_reg) begin
            aw_addr_reg  <= ADDR_CTRL;
            w_data_reg   <= op_reg ? 32'h2 : 32'h1;
            aw_valid_reg <= 1'b1;
            w_valid_reg  <= 1'b1;
            b_ready_reg  <= 1'b1;
            act_reg      <= 1'b1;
          end else if (b_fire) begin
            act_reg <= 1'b0;
            if (b_err) begin
              state_reg <= S_FIN;
              done_reg  <= 1'b1;
              err_reg   <= 2'd1;
            end else begin
              state_reg <= S_POLL_RD;
            end
          end
        end

        S_POLL_RD: begin
          if (!act_reg) begin
            ar_addr_reg  <= ADDR_STATUS;
            ar_valid_reg <= 1'b1;
            r_ready_reg  <= 1'b1;
            act_reg      <= 1'b1;
          end else if (r_fire) begin
            act_reg <= 1'b0;
            if (r_err) begin
              state_reg <= S_FIN;
              done_reg  <= 1'b1;
              err_reg   <= 2'd1;
            end else if (m_axil_rdata[1]) begin
              state_reg <= op_reg ? S_CLR_WR : S_DATA_RD;
            end else if (poll_cnt_reg == POLL_LAST) begin
              state_reg <= S_FIN;
              done_reg  <= 1'b1;
              err_reg   <= 2'd2;
            end else begin
              poll_cnt_reg <= poll_cnt_reg + POLL_W'(1);
            end
          end
        end

        // The next DATA read waits until the previous word has left on dout.
        S_DATA_RD: begin
          if (dout_valid_reg) begin
            if (dout_ready_i) begin
              dout_valid_reg <= 1'b0;
              dout_last_reg  <= 1'b0;
              if (idx_reg == LAST_IDX) begin
                state_reg <= S_CLR_WR;
                idx_reg   <= '0;
              end else begin
                idx_reg <= idx_reg + IDX_W'(1);
              end
            end
          end else if (!act_reg) begin
            ar_addr_reg  <= data_addr(idx_reg);
            ar_valid_reg <= 1'b1;
            r_ready_reg  <= 1'b1;
            act_reg      <= 1'b1;
          end else if (r_fire) begin
            act_reg <= 1'b0;
            if (r_err) begin
              state_reg <= S_FIN;
              done_reg  <= 1'b1;
              err_reg   <= 2'd1;
            end else begin
              dout_data_reg  <= m_axil_rdata;
              dout_valid_reg <= 1'b1;
              dout_last_reg  <= (idx_reg == LAST_IDX);
            end
          end
        end

        S_CLR_WR: begin
          if (!act_reg) begin
            aw_addr_reg  <= ADDR_STATUS;
            w_data_reg   <= 32'h2;
            aw_valid_reg <= 1'b1;
            w_valid_reg  <= 1'b1;
            b_ready_reg  <= 1'b1;
            act_reg      <= 1'b1;
          end else if (b_fire) begin
            act_reg   <= 1'b0;
            state_reg <= S_FIN;
            done_reg  <= 1'b1;
            err_reg   <= b_err ? 2'd1 : 2'd0;
          end
        end

        S_FIN: begin
          state_reg     <= S_IDLE;
          busy_reg      <= 1'b0;
          cmd_ready_reg <= 1'b1;
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o    = cmd_ready_reg;
  assign busy_o         = busy_reg;
  assign done_o         = done_reg;
  assign err_o          = err_reg;
  assign din_ready_o    = din_ready_reg;
  assign dout_valid_o   = dout_valid_reg;
  assign dout_data_o    = dout_data_reg;
  assign dout_last_o    = dout_last_reg;
  assign m_axil_awaddr  = aw_addr_reg;
  assign m_axil_awvalid = aw_valid_reg;
  assign m_axil_wdata   = w_data_reg;
  assign m_axil_wvalid  = w_valid_reg;
  assign m_axil_bready  = b_ready_reg;
  assign m_axil_araddr  = ar_addr_reg;
  assign m_axil_arvalid = ar_valid_reg;

endmodule

// File: tb/tb_loom_scan_seq.sv
// Directed bench for loom_scan_seq: behavioural AXI-Lite scan-controller slave plus linear command sequence.
module tb_loom_scan_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic        din_valid, din_ready;
  logic [31:0] din_data;
  logic        dout_valid, dout_ready, dout_last;
  logic [31:0] dout_data;
  logic        done, busy;
  logic [1:0]  err;
  logic [11:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [1:0]  bresp, rresp;

  loom_scan_seq #(.CHAIN_LENGTH(64), .POLL_LIMIT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .din_valid_i(din_valid), .din_ready_o(din_ready), .din_data_i(din_data),
    .dout_valid_o(dout_valid), .dout_ready_i(dout_ready), .dout_data_o(dout_data),
    .dout_last_o(dout_last), .done_o(done), .err_o(err), .busy_o(busy),
    .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
  );

  // Slave configuration, set by the stimulus block.
  int          done_after;
  logic [11:0] err_addr;
  logic [31:0] length_val;
  logic [31:0] data_mem [0:1];
  logic [31:0] din_mem  [0:1];
  logic        din_en;
  logic        log_clr;

  // Observation logs, owned by the monitor block.
  logic [11:0] wr_addr_log [0:7];
  logic [31:0] wr_data_log [0:7];
  logic [31:0] dout_log    [0:3];
  logic        dout_last_log [0:3];
  int          wr_cnt, status_rd_cnt, data_rd_cnt, len_rd_cnt;
  int          dout_cnt, done_cnt, overlap_cnt, din_ptr;
  logic [1:0]  last_err;

  logic [11:0] aw_lat;
  logic [31:0] w_lat;
  logic        aw_got, w_got;

  int checks = 0;
  int errors = 0;

  assign awready   = 1'b1;
  assign wready    = 1'b1;
  assign rresp     = 2'b00;
  assign din_valid = din_en && (din_ptr < 2);
  assign din_data  = (din_ptr < 2) ? din_mem[din_ptr[0]] : 32'h0;

  always @(posedge clk) begin
    if (!rst_n) begin
      bvalid <= 1'b0; bresp <= 2'b00; arready <= 1'b0; rvalid <= 1'b0; rdata <= 32'h0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_lat <= 12'h0; w_lat <= 32'h0;
    end else begin
      if (awvalid && awready) begin aw_lat <= awaddr; aw_got <= 1'b1; end
      if (wvalid && wready) begin w_lat <= wdata; w_got <= 1'b1; end
      if (aw_got && w_got && !bvalid) begin
        bvalid <= 1'b1;
        bresp  <= (aw_lat == err_addr) ? 2'b10 : 2'b00;
        aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      arready <= arvalid && !arready && !rvalid;
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        if (araddr == 12'h000)
          rdata <= ((done_after != 0) && (status_rd_cnt + 1 >= done_after)) ? 32'h2 : 32'h1;
        else if (araddr == 12'h008)
          rdata <= length_val;
        else
          rdata <= data_mem[araddr[2]];
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (log_clr) begin
      wr_cnt <= 0; status_rd_cnt <= 0; data_rd_cnt <= 0; len_rd_cnt <= 0;
      dout_cnt <= 0; done_cnt <= 0; overlap_cnt <= 0; din_ptr <= 0; last_err <= 2'd0;
    end else begin
      if (bvalid && bready) begin
        if (wr_cnt < 8) begin
          wr_addr_log[wr_cnt[2:0]] <= aw_lat;
          wr_data_log[wr_cnt[2:0]] <= w_lat;
        end
        wr_cnt <= wr_cnt + 1;
      end
      if (arvalid && arready) begin
        if (araddr == 12'h000) status_rd_cnt <= status_rd_cnt + 1;
        else if (araddr == 12'h008) len_rd_cnt <= len_rd_cnt + 1;
        else data_rd_cnt <= data_rd_cnt + 1;
      end
      if (dout_valid && dout_ready) begin
        if (dout_cnt < 4) begin
          dout_log[dout_cnt[1:0]]      <= dout_data;
          dout_last_log[dout_cnt[1:0]] <= dout_last;
        end
        dout_cnt <= dout_cnt + 1;
      end
      if (done) begin done_cnt <= done_cnt + 1; last_err <= err; end
      if (arvalid && (awvalid || wvalid)) overlap_cnt <= overlap_cnt + 1;
      if (din_valid && din_ready) din_ptr <= din_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    @(negedge clk); log_clr = 1'b1;
    @(negedge clk); log_clr = 1'b0;
  endtask

  task automatic send_cmd(input logic op);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("accept_busy", 32'(busy), 32'h1);
    chk("accept_cmd_ready_low", 32'(cmd_ready), 32'h0);
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (done_cnt == 0 && n < max) begin @(negedge clk); n++; end
    chk(tag, 32'(done_cnt), 32'h1);
    chk({tag, "_busy_low"}, 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    chk({tag, "_single_pulse"}, 32'(done_cnt), 32'h1);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; din_en = 1'b0; dout_ready = 1'b1;
    done_after = 3; err_addr = 12'hFFF; length_val = 32'd64; log_clr = 1'b1;
    data_mem[0] = 32'hCAFEF00D; data_mem[1] = 32'h12345678;
    din_mem[0] = 32'hA5A5A5A5; din_mem[1] = 32'h0F0F0F0F;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'h0);
    chk("rst_done_err", 32'({done, err}), 32'h0);
    chk("rst_streams", 32'({din_ready, dout_valid}), 32'h0);
    chk("rst_addr", 32'({awaddr, araddr}), 32'h0);
    rst_n = 1'b1; log_clr = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);

    // Capture: done on 3rd poll.
    clear_logs();
    send_cmd(1'b0);
`ifndef LOOM_SCAN_SEQ_CHECK_LENGTH_EN
    chk("cap_first_aw", 32'({awvalid, wvalid}), 32'h3);
    chk("cap_first_awaddr", 32'(awaddr), 32'h4);
    chk("cap_first_wdata", wdata, 32'h1);
`endif
    wait_done("cap_done", 400);
    chk("cap_err", 32'(last_err), 32'h0);
    chk("cap_status_reads", 32'(status_rd_cnt), 32'd3);
    chk("cap_data_reads", 32'(data_rd_cnt), 32'd2);
    chk("cap_dout_cnt", 32'(dout_cnt), 32'd2);
    chk("cap_dout0", dout_log[0], 32'hCAFEF00D);
    chk("cap_dout1", dout_log[1], 32'h12345678);
    chk("cap_last0", 32'(dout_last_log[0]), 32'h0);
    chk("cap_last1", 32'(dout_last_log[1]), 32'h1);
    chk("cap_wr_cnt", 32'(wr_cnt), 32'd2);
    chk("cap_wr0_addr", 32'(wr_addr_log[0]), 32'h4);
    chk("cap_wr0_data", wr_data_log[0], 32'h1);
    chk("cap_wr1_addr", 32'(wr_addr_log[1]), 32'h0);
    chk("cap_wr1_data", wr_data_log[1], 32'h2);

    // Restore two words.
    done_after = 1;
    clear_logs();
    din_en = 1'b1;
    send_cmd(1'b1);
`ifndef LOOM_SCAN_SEQ_CHECK_LENGTH_EN
    chk("rst_din_ready", 32'(din_ready), 32'h1);
`endif
    wait_done("res_done", 400);
    din_en = 1'b0;
    chk("res_err", 32'(last_err), 32'h0);
    chk("res_din_taken", 32'(din_ptr), 32'd2);
    chk("res_wr_cnt", 32'(wr_cnt), 32'd4);
    chk("res_wr0", {8'h0, wr_addr_log[0], 12'h0}, {8'h0, 12'h010, 12'h0});
    chk("res_wr0_data", wr_data_log[0], 32'hA5A5A5A5);
    chk("res_wr1", 32'(wr_addr_log[1]), 32'h14);
    chk("res_wr1_data", wr_data_log[1], 32'h0F0F0F0F);
    chk("res_ctrl", {20'h0, wr_addr_log[2]} ^ (wr_data_log[2] << 16), 32'h0002_0004);
    chk("res_clr", {20'h0, wr_addr_log[3]} ^ (wr_data_log[3] << 16), 32'h0002_0000);
    chk("res_status_reads", 32'(status_rd_cnt), 32'd1);
    chk("res_no_dout", 32'(dout_cnt), 32'd0);

    // Poll timeout: never done, POLL_LIMIT=4.
    done_after = 0;
    clear_logs();
    send_cmd(1'b0);
    wait_done("to_done", 400);
    chk("to_err", 32'(last_err), 32'd2);
    chk("to_status_reads", 32'(status_rd_cnt), 32'd4);
    chk("to_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("to_wr0_addr", 32'(wr_addr_log[0]), 32'h4);
    chk("to_data_reads", 32'(data_rd_cnt), 32'd0);

    // SLVERR on CONTROL write.
    done_after = 1; err_addr = 12'h004;
    clear_logs();
    send_cmd(1'b0);
    wait_done("se_done", 400);
    err_addr = 12'hFFF;
    chk("se_err", 32'(last_err), 32'd1);
    chk("se_status_reads", 32'(status_rd_cnt), 32'd0);
    chk("se_wr_cnt", 32'(wr_cnt), 32'd1);

    // dout backpressure stalls DATA_RD.
    data_mem[0] = 32'h11112222; data_mem[1] = 32'h33334444;
    dout_ready = 1'b0;
    clear_logs();
    send_cmd(1'b0);
    n = 0;
    while (!dout_valid && n < 200) begin @(negedge clk); n++; end
    chk("bp_dout_seen", 32'(dout_valid), 32'h1);
    repeat (10) @(negedge clk);
    chk("bp_one_read", 32'(data_rd_cnt), 32'd1);
    chk("bp_dout_held", 32'(dout_valid), 32'h1);
    chk("bp_dout_data", dout_data, 32'h11112222);
    chk("bp_not_last", 32'(dout_last), 32'h0);
    dout_ready = 1'b1;
    wait_done("bp_done", 400);
    chk("bp_err", 32'(last_err), 32'h0);
    chk("bp_dout_cnt", 32'(dout_cnt), 32'd2);
    chk("bp_dout1", dout_log[1], 32'h33334444);
    chk("bp_data_reads", 32'(data_rd_cnt), 32'd2);

`ifdef LOOM_SCAN_SEQ_CHECK_LENGTH_EN
    // Length mismatch, then match.
    length_val = 32'd32;
    clear_logs();
    send_cmd(1'b0);
    wait_done("len_bad_done", 400);
    chk("len_bad_err", 32'(last_err), 32'd3);
    chk("len_bad_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("len_bad_len_reads", 32'(len_rd_cnt), 32'd1);
    length_val = 32'd64;
    clear_logs();
    send_cmd(1'b0);
    wait_done("len_ok_done", 400);
    chk("len_ok_err", 32'(last_err), 32'd0);
    chk("len_ok_wr_cnt", 32'(wr_cnt), 32'd2);
    chk("len_ok_dout_cnt", 32'(dout_cnt), 32'd2);
`endif

    // Reset while a STATUS read is pending.
    done_after = 0;
    clear_logs();
    send_cmd(1'b0);
    n = 0;
    while (!(arvalid && !arready && araddr == 12'h000) && n < 100) begin @(negedge clk); n++; end
    chk("mr_arvalid_seen", 32'(arvalid), 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mr_valids", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("mr_done", 32'(done), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mr_cmd_ready_after", 32'(cmd_ready), 32'h1);
    chk("no_overlap", 32'(overlap_cnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
